mult_op_sequencer: RTL and testbench

MULT_OP_SEQUENCER -- requirements
Module: mult_op_sequencer

---
 rtl/mul_pkg.sv | 21 ++
 rtl/mult_op_sequencer_if.sv | 27 ++
 rtl/wrap_counter.sv | 22 ++
 rtl/mult_op_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mult_op_sequencer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier operation sequencer.
package mul_pkg;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCompute,
        StCapture,
        StRead,
        StDone,
        StClear
    } seq_state_e;

    // Default operand width.
    localparam int unsigned MulDefaultN = 32;

    // Edges from the operand transfer to the first edge with outValid high.
    localparam int unsigned SEQ_LATENCY = 5;

endpackage

// File: rtl/mult_op_sequencer_if.sv
// Operand/result handshake bundle between the sequencer and its client.
interface mult_op_sequencer_if
    import mul_pkg::*;
#(
    parameter int unsigned N = MulDefaultN
);
    logic           inValid;
    logic           inReady;
    logic [N-1:0]   inA;
    logic [N-1:0]   inB;
    logic           outValid;
    logic           outReady;
    logic [2*N-1:0] outProduct;
    logic           outError;

    // Client side: issues operands, consumes results.
    modport master (
        output inValid, inA, inB, outReady,
        input  inReady, outValid, outProduct, outError
    );

    // Sequencer side.
    modport slave (
        input  inValid, inA, inB, outReady,
        output inReady, outValid, outProduct, outError
    );
endinterface

// File: rtl/wrap_counter.sv
// Free-running event counter that wraps modulo 2^CW.
module wrap_counter #(
    parameter int unsigned CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    output logic [CW-1:0] count_o
);
    logic [CW-1:0] count_q;

    // Count one per enabled cycle; natural overflow gives the wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/mult_op_sequencer.sv
// Sequences one signed multiply through an external registered multiplier:
// load operands, compute, capture, read, hand the result downstream, and
// clear the multiplier after an errored operation.
module mult_op_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned N  = MulDefaultN,
    parameter int unsigned CW = 16
) (
    input  logic                  clk,
    input  logic                  resetN,
    mult_op_sequencer_if.slave    bus,
    output logic [N-1:0]          mulA,
    output logic [N-1:0]          mulB,
    output logic                  writeEnableA,
    output logic                  writeEnableB,
    output logic                  readEnableA,
    output logic                  readEnableB,
    output logic                  writeEnableOut,
    output logic                  readEnableOut,
    output logic                  resetA,
    output logic                  resetB,
    output logic                  resetOut,
    input  logic [2*N-1:0]        mulProduct,
    input  logic                  accessErrorA,
    input  logic                  accessErrorB,
    input  logic                  accessErrorOut,
    output logic [CW-1:0]         opCount,
    output logic [CW-1:0]         errCount
);
    seq_state_e     state_q;
    logic           settle_q;   // first LOAD cycle: operands settle before the write
    logic           err_q;      // sticky access error for the current operation
    logic           in_ready_q;
    logic           out_valid_q;
    logic           out_error_q;
    logic [2*N-1:0] out_product_q;
    logic [N-1:0]   mul_a_q, mul_b_q;
    logic           we_a_q, we_b_q, re_a_q, re_b_q, we_out_q, re_out_q;
    logic           clr_q;
    logic           access_err;
    logic           op_done;

    assign access_err = accessErrorA | accessErrorB | accessErrorOut;
    assign op_done    = (state_q == StDone) && out_valid_q && bus.outReady;

    // Sequencer FSM with all control outputs registered.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= StIdle;
            settle_q      <= 1'b0;
            err_q         <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_error_q   <= 1'b0;
            out_product_q <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            we_a_q        <= 1'b0;
            we_b_q        <= 1'b0;
            re_a_q        <= 1'b0;
            re_b_q        <= 1'b0;
            we_out_q      <= 1'b0;
            re_out_q      <= 1'b0;
            clr_q         <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.inValid) begin
                        mul_a_q    <= bus.inA;
                        mul_b_q    <= bus.inB;
                        in_ready_q <= 1'b0;
                        err_q      <= 1'b0;
                        settle_q   <= 1'b1;
                        state_q    <= StLoad;
                    end
                end
                StLoad: begin
                    err_q <= err_q | access_err;
                    if (settle_q) begin
                        settle_q <= 1'b0;
                        we_a_q   <= 1'b1;
                        we_b_q   <= 1'b1;
                    end else begin
                        we_a_q  <= 1'b0;
                        we_b_q  <= 1'b0;
                        re_a_q  <= 1'b1;
                        re_b_q  <= 1'b1;
                        state_q <= StCompute;
                    end
                end
                StCompute: begin
                    err_q    <= err_q | access_err;
                    re_a_q   <= 1'b0;
                    re_b_q   <= 1'b0;
                    we_out_q <= 1'b1;
                    state_q  <= StCapture;
                end
                StCapture: begin
                    err_q    <= err_q | access_err;
                    we_out_q <= 1'b0;
                    re_out_q <= 1'b1;
                    state_q  <= StRead;
                end
                StRead: begin
                    // Product is valid on mulProduct while readEnableOut is high.
                    re_out_q      <= 1'b0;
                    out_product_q <= mulProduct;
                    out_error_q   <= err_q | access_err;
                    out_valid_q   <= 1'b1;
                    state_q       <= StDone;
                end
                StDone: begin
                    if (op_done) begin
                        out_valid_q <= 1'b0;
                        out_error_q <= 1'b0;
                        if (out_error_q) begin
                            clr_q   <= 1'b1;
                            state_q <= StClear;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= StIdle;
                        end
                    end
                end
                StClear: begin
                    clr_q      <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= StIdle;
                end
                default: begin
                    in_ready_q <= 1'b1;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign bus.inReady    = in_ready_q;
    assign bus.outValid   = out_valid_q;
    assign bus.outError   = out_error_q;
    assign bus.outProduct = out_product_q;
    assign mulA           = mul_a_q;
    assign mulB           = mul_b_q;
    assign writeEnableA   = we_a_q;
    assign writeEnableB   = we_b_q;
    assign readEnableA    = re_a_q;
    assign readEnableB    = re_b_q;
    assign writeEnableOut = we_out_q;
    assign readEnableOut  = re_out_q;
    assign resetA         = clr_q;
    assign resetB         = clr_q;
    assign resetOut       = clr_q;

    wrap_counter #(.CW(CW)) u_op_count (
        .clk_i   (clk),
        .rst_ni  (resetN),
        .en_i    (op_done),
        .count_o (opCount)
    );

    wrap_counter #(.CW(CW)) u_err_count (
        .clk_i   (clk),
        .rst_ni  (resetN),
        .en_i    (op_done && out_error_q),
        .count_o (errCount)
    );
endmodule

// File: tb/tb_mult_op_sequencer.sv
// Bench for mult_op_sequencer: behavioural registered multiplier, directed
// operations, expected results queued at issue and checked by a monitor.
module tb_mult_op_sequencer;
    import mul_pkg::*;

    localparam int unsigned N  = 32;
    localparam int unsigned CW = 16;

    typedef struct {
        logic [63:0] prod;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic [N-1:0] mulA, mulB;
    logic writeEnableA, writeEnableB, readEnableA, readEnableB;
    logic writeEnableOut, readEnableOut, resetA, resetB, resetOut;
    logic [2*N-1:0] mulProduct;
    logic accessErrorA = 1'b0, accessErrorB = 1'b0, accessErrorOut = 1'b0;
    logic [CW-1:0] opCount, errCount;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   xfer_cyc = -100;
    bit   active = 0;
    logic prev_ov = 1'b0;
    exp_t exp_q[$];
    logic [5:0] en_tbl [6] = '{6'b000000, 6'b110000, 6'b001100,
                               6'b000010, 6'b000001, 6'b000000};

    mult_op_sequencer_if #(.N(N)) bus ();

    mult_op_sequencer #(.N(N), .CW(CW)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .bus            (bus),
        .mulA           (mulA),
        .mulB           (mulB),
        .writeEnableA   (writeEnableA),
        .writeEnableB   (writeEnableB),
        .readEnableA    (readEnableA),
        .readEnableB    (readEnableB),
        .writeEnableOut (writeEnableOut),
        .readEnableOut  (readEnableOut),
        .resetA         (resetA),
        .resetB         (resetB),
        .resetOut       (resetOut),
        .mulProduct     (mulProduct),
        .accessErrorA   (accessErrorA),
        .accessErrorB   (accessErrorB),
        .accessErrorOut (accessErrorOut),
        .opCount        (opCount),
        .errCount       (errCount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: only honours correctly ordered enables.
    logic signed [N-1:0]   ra, rb;
    logic signed [2*N-1:0] rprod, rout;
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ra <= '0; rb <= '0; rprod <= '0; rout <= '0;
        end else begin
            if (resetA) ra <= '0; else if (writeEnableA) ra <= mulA;
            if (resetB) rb <= '0; else if (writeEnableB) rb <= mulB;
            if (readEnableA && readEnableB) rprod <= ra * rb;
            if (resetOut) rout <= '0; else if (writeEnableOut) rout <= rprod;
        end
    end
    assign mulProduct = readEnableOut ? rout : '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: enable ordering, latency and scoreboard pops.
    always @(negedge clk) begin
        int k;
        exp_t e;
        if (!resetN) begin
            active = 0;
            prev_ov = 1'b0;
        end else begin
            if (bus.inValid && bus.inReady) begin
                xfer_cyc = cyc + 1;
                active = 1;
            end
            if (active) begin
                k = cyc - xfer_cyc;
                if (k >= 0 && k <= 5) begin
                    chk("enable_seq", {writeEnableA, writeEnableB, readEnableA, readEnableB,
                                       writeEnableOut, readEnableOut}, en_tbl[k]);
                    if (k == 5) active = 0;
                end
            end
            if (bus.outValid && !prev_ov) chk("latency", cyc - xfer_cyc, SEQ_LATENCY);
            prev_ov = bus.outValid;
            if (bus.outValid && bus.outReady) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got %0h with no expectation",
                             bus.outProduct);
                end else begin
                    e = exp_q.pop_front();
                    chk("product", bus.outProduct, e.prod);
                    chk("out_error", {63'd0, bus.outError}, {63'd0, e.err});
                end
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ctl"}, {bus.outValid, bus.outError, writeEnableA, writeEnableB,
                            readEnableA, readEnableB, writeEnableOut, readEnableOut,
                            resetA, resetB, resetOut}, 64'd0);
        chk({tag, "_inready"}, {63'd0, bus.inReady}, 64'd1);
        chk({tag, "_data"}, {mulA, mulB}, 64'd0);
        chk({tag, "_prod"}, bus.outProduct, 64'd0);
        chk({tag, "_cnt"}, {opCount, errCount}, 64'd0);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        resetN = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {63'd0, bus.inReady}, 64'd1);
    endtask

    // Called at #1 after a posedge; returns #1 after the transfer edge.
    task automatic issue(input int a, input int b, input logic e, input bit push);
        int n = 0;
        bus.inValid = 1'b1;
        bus.inA = a;
        bus.inB = b;
        @(negedge clk);
        while (!bus.inReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.inReady) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: inReady=0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
        if (push) exp_q.push_back('{prod: 64'(longint'(a) * longint'(b)), err: e});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        int n = 0;
        @(negedge clk);
        while (!bus.outValid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.outValid) begin
            total++;
            bad++;
            $display("FAIL outvalid_timeout: outValid=0 expected 1");
        end
    endtask

    initial begin
        int av[3] = '{-4, 10, -50};
        int bv[3] = '{-7, -4, 5};
        int seen;
        bus.inValid = 1'b0;
        bus.inA = '0;
        bus.inB = '0;
        bus.outReady = 1'b1;

        // Single operation.
        do_reset();
        issue(5, 6, 1'b0, 1);
        drain();
        chk("opcount_single", {48'd0, opCount}, 64'd1);

        // Back-to-back signed operations.
        do_reset();
        for (int i = 0; i < 3; i++) issue(av[i], bv[i], 1'b0, 1);
        drain();
        chk("opcount_b2b", {48'd0, opCount}, 64'd3);
        chk("errcount_b2b", {48'd0, errCount}, 64'd0);

        // Downstream stall holds the result; stray inValid is ignored.
        do_reset();
        bus.outReady = 1'b0;
        issue(32, 23, 1'b0, 1);
        wait_out_valid();
        @(posedge clk);
        #1;
        bus.inValid = 1'b1;
        bus.inA = 7;
        bus.inB = 9;
        repeat (4) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, bus.outValid}, 64'd1);
            chk("hold_prod", bus.outProduct, 64'd736);
            chk("hold_inready", {63'd0, bus.inReady}, 64'd0);
            chk("hold_operands", {mulA, mulB}, {32'd32, 32'd23});
        end
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
        bus.outReady = 1'b1;
        drain();
        chk("release_idle", {63'd0, bus.inReady}, 64'd1);
        chk("opcount_hold", {48'd0, opCount}, 64'd1);

        // Access error during COMPUTE: flagged result, then a clear pulse.
        do_reset();
        issue(1234, 0, 1'b1, 1);
        repeat (2) @(posedge clk);
        #1;
        accessErrorA = 1'b1;
        @(posedge clk);
        #1;
        accessErrorA = 1'b0;
        wait_out_valid();
        @(posedge clk);
        #1;
        chk("clear_on", {61'd0, resetA, resetB, resetOut}, 64'd7);
        chk("clear_inready", {63'd0, bus.inReady}, 64'd0);
        @(posedge clk);
        #1;
        chk("clear_off", {61'd0, resetA, resetB, resetOut}, 64'd0);
        chk("clear_to_idle", {63'd0, bus.inReady}, 64'd1);
        chk("errcount", {48'd0, errCount}, 64'd1);
        chk("opcount_err", {48'd0, opCount}, 64'd1);

        // Reset during CAPTURE aborts the operation and clears the counters.
        issue(99, 1, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b0;
        #1;
        chk_reset_state("abort");
        @(posedge clk);
        #1;
        resetN = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", {63'd0, bus.inReady}, 64'd1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.outValid) seen++;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        chk("abort_cnt", {opCount, errCount}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
